// File: rtl/wb_hram_arb_pkg.sv
// Shared types and constants for the three-master HyperRAM Wishbone arbiter.
package wb_hram_arb_pkg;

  localparam int NM = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'd0;
  localparam logic [2:0] CTI_INCR    = 3'd2;
  localparam logic [2:0] CTI_EOB     = 3'd7;

  localparam logic [1:0] M_CPU = 2'd0;
  localparam logic [1:0] M_SD  = 2'd1;
  localparam logic [1:0] M_FRM = 2'd2;

  function automatic logic [1:0] oh2idx(input logic [NM-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NM; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_hram_arbiter_rr_pick.sv
// Combinational round-robin pick: highest priority goes to the master after 'last'.
module rr_pick
  import wb_hram_arb_pkg::*;
(
  input  logic [NM-1:0] req,
  input  logic [1:0]    last,
  output logic [NM-1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (last)
      M_CPU: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      M_SD: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/wb_hram_arbiter.sv
// Three-master Wishbone arbiter in front of one HyperRAM slave; grant held for a whole cyc tenure.
// Optional stall watchdog enabled by defining WB_HRAM_ARB_TIMEOUT_EN.
module wb_hram_arbiter
  import wb_hram_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic [NM-1:0][AW-1:0]     m_adr_i,
  input  logic [NM-1:0][DW-1:0]     m_dat_i,
  input  logic [NM-1:0][DW/8-1:0]   m_sel_i,
  input  logic [NM-1:0]             m_we_i,
  input  logic [NM-1:0]             m_cyc_i,
  input  logic [NM-1:0]             m_stb_i,
  input  logic [NM-1:0][2:0]        m_cti_i,
  input  logic [NM-1:0][1:0]        m_bte_i,
  output logic [NM-1:0][DW-1:0]     m_dat_o,
  output logic [NM-1:0]             m_ack_o,
  output logic [NM-1:0]             m_err_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic [DW/8-1:0]           s_sel_o,
  output logic                      s_we_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic [DW-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  output logic [NM-1:0]             grant_o
);

  state_t          state_q, state_d;
  logic [NM-1:0]   grant_q, grant_d;
  logic [1:0]      last_q, last_d;
  logic [NM-1:0]   pick;
  logic [1:0]      gidx;
  logic            busy;
  logic            cyc_g;
  logic            stb_g;
  logic            abort;
  logic            live;

  rr_pick u_pick (
    .req  (m_cyc_i),
    .last (last_q),
    .gnt  (pick)
  );

  assign gidx  = oh2idx(grant_q);
  assign busy  = (state_q == S_BUSY);
  assign cyc_g = m_cyc_i[gidx];
  assign stb_g = m_stb_i[gidx];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (|m_cyc_i) begin
          grant_d = pick;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Tenure ends only when the owner releases cyc; no pre-emption.
        if (!cyc_g) begin
          grant_d = '0;
          last_d  = gidx;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= M_FRM;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Outputs are gated by reset so an in-flight burst is cut off in the reset cycle itself.
  assign live    = busy && wb_rst_ni && !abort;
  assign s_cyc_o = live && cyc_g;
  assign s_stb_o = live && stb_g;
  assign s_adr_o = m_adr_i[gidx];
  assign s_dat_o = m_dat_i[gidx];
  assign s_sel_o = m_sel_i[gidx];
  assign s_we_o  = m_we_i[gidx];
  assign s_cti_o = m_cti_i[gidx];
  assign s_bte_o = m_bte_i[gidx];

  assign m_dat_o = {NM{s_dat_i}};
  assign m_ack_o = (busy && wb_rst_ni && s_ack_i) ? grant_q : '0;
  assign grant_o = wb_rst_ni ? grant_q : '0;

`ifdef WB_HRAM_ARB_TIMEOUT_EN
  localparam logic [9:0] TO_LIM = 10'(TIMEOUT);

  logic [9:0] to_cnt_q;
  logic       abort_q;
  logic       to_hit;

  assign abort   = abort_q;
  assign to_hit  = busy && !abort_q && (to_cnt_q == TO_LIM);
  assign m_err_o = (to_hit && wb_rst_ni) ? grant_q : '0;

  // After the error pulse the slave side stays quiet until the owner lets go of cyc.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      to_cnt_q <= '0;
      abort_q  <= 1'b0;
    end else if (!busy || !cyc_g) begin
      to_cnt_q <= '0;
      abort_q  <= 1'b0;
    end else if (to_hit) begin
      to_cnt_q <= '0;
      abort_q  <= 1'b1;
    end else if (s_ack_i) begin
      to_cnt_q <= '0;
    end else if (stb_g && !abort_q) begin
      to_cnt_q <= to_cnt_q + 10'd1;
    end
  end
`else
  assign abort   = 1'b0;
  assign m_err_o = '0;
`endif

endmodule

// File: doc/wb_hram_arbiter.md
WB_HRAM_ARBITER -- requirements
Module: wb_hram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, Wishbone data width; SEL width is DW/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, the stalled-cycle limit before abort (range 2..1023).
REQ-004 SHALL have port wb_clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port wb_rst_ni, input, 1, a synchronous active-low reset.
REQ-006 SHALL have ports m_adr_i/m_dat_i/m_sel_i/m_we_i/m_cyc_i/m_stb_i/m_cti_i/m_bte_i, all inputs, packed 3x(AW/DW/DW/8/1/1/3/2). These are the master requests: index 0 CPU, 1 SD controller, 2 frame streamer.
REQ-007 SHALL have ports m_dat_o, m_ack_o, m_err_o, all outputs, widths 3xDW, 3, 3, carrying per-master responses.
REQ-008 SHALL have ports s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o/s_cti_o/s_bte_o, all outputs, widths AW/DW/DW/8/1/1/3/2, forming the single HyperRAM slave request.
REQ-009 SHALL have ports s_dat_i and s_ack_i, inputs, widths DW and 1, carrying the slave response.
REQ-010 SHALL have port grant_o, output, 3, a one-hot copy of the current grant (status/debug).

Function
REQ-011 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-012 In IDLE with any m_cyc_i high, SHALL register a one-hot grant chosen round-robin starting at (last+1) mod 3, and enter BUSY on the next edge.
REQ-013 Arbitration latency SHALL be one cycle: if m_cyc_i rises at edge N, s_cyc_o can first be high in the cycle after edge N+1.
REQ-014 In BUSY, s_* outputs SHALL be a combinational mux of the granted master's inputs; s_cyc_o and s_stb_o SHALL be 0 in IDLE.
REQ-015 m_ack_o[g] SHALL equal s_ack_i for the granted g only; ungranted ack/err SHALL be 0; every m_dat_o slice SHALL carry s_dat_i.
REQ-016 The grant SHALL be held for as long as the granted m_cyc_i stays high, covering incrementing CTI bursts and back-to-back single cycles; no pre-emption.
REQ-017 When the granted m_cyc_i goes low, SHALL return to IDLE, set last to the granted index, and insert exactly one idle cycle before any new grant.
REQ-018 Simultaneous requests SHALL resolve strictly round-robin; a continuously requesting master SHALL wait at most two other tenures.
REQ-019 A granted master dropping m_cyc_i in the same cycle as s_ack_i SHALL still receive that ack.
REQ-020 s_ack_i arriving in IDLE SHALL be ignored (no m_ack_o asserted).

Reset
REQ-021 With wb_rst_ni low at an edge, SHALL set state IDLE, grant 0, last=2 (so master 0 wins first), and clear the timeout counter.
REQ-022 While in reset and on the first cycle after it, all m_ack_o, m_err_o, s_cyc_o, s_stb_o and grant_o SHALL be 0.
REQ-023 Reset asserted mid-burst SHALL abort immediately with no ack/err issued; masters are reset by the same signal.

Configuration
REQ-024 Macro WB_HRAM_ARB_TIMEOUT_EN, when defined: an 10-bit counter SHALL increment each BUSY cycle with s_stb_o high and s_ack_i low, and clear on s_ack_i.
REQ-025 When that counter reaches TIMEOUT, SHALL pulse m_err_o[g] for one cycle and force s_cyc_o/s_stb_o low until the granted m_cyc_i drops; then the REQ-017 rules apply.
REQ-026 Macro WB_HRAM_ARB_TIMEOUT_EN undefined: no counter, m_err_o SHALL be constant 0, and the TIMEOUT parameter is unused.

Structure
REQ-027 Package wb_hram_arb_pkg SHALL hold the state enum, the NM=3 constant, CTI codes (CLASSIC=0, INCR=2, EOB=7) and the master index constants.
REQ-028 Sub-module rr_pick SHALL be combinational (req[2:0], last[1:0] -> one-hot gnt); everything else SHALL be in wb_hram_arbiter.

Verification
REQ-029 The bench SHALL cover the following after reset: single m0 read with s_ack_i 3 cycles later -> grant_o=001, exactly one m_ack_o[0], s_adr_o=m_adr_i[0].
REQ-030 The bench SHALL cover: all three cyc high at once, each holding 4 beats -> grant order 001,010,100 with one idle cycle between tenures.
REQ-031 The bench SHALL cover: m2 8-beat INCR burst ending with EOB while m0 requests -> m0 waits until m2 cyc drops, no interleaving, all 8 acks to m2.
REQ-032 The bench SHALL cover, with WB_HRAM_ARB_TIMEOUT_EN and TIMEOUT=16: slave never acks -> m_err_o[g] pulses 16 cycles after stb, s_cyc_o drops, the next master is granted.
REQ-033 The bench SHALL cover: wb_rst_ni low for 1 cycle mid-burst of m1 -> outputs match REQ-022, and the next request from m0 and m1 together grants m0.
REQ-034 The bench SHALL cover: constrained-random cyc/stb on all masters for 10k cycles -> at most one grant bit set, every ack routed to the granted master, no starvation beyond two tenures.
